// File: rtl/e1_led_blinker_n_pkg.sv
// e1_led_blinker_n shared types: LED mode codes, transfer FSM states,
// counter widths and the per-LED base level helper.
package e1_led_blinker_n_pkg;

  typedef enum logic [1:0] {
    LED_OFF  = 2'b00,
    LED_ON   = 2'b01,
    LED_SLOW = 2'b10,
    LED_FAST = 2'b11
  } led_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_WAIT  = 2'd2
  } xfer_st_e;

  localparam int FLASH_W   = 4;
  localparam int REFRESH_W = 8;
  localparam int PHASE_W   = 3;

  function automatic logic led_base(
    input logic [1:0] mode,
    input logic       slow,
    input logic       fast
  );
    logic lvl;
    lvl = 1'b0;
    unique case (mode)
      LED_OFF:  lvl = 1'b0;
      LED_ON:   lvl = 1'b1;
      LED_SLOW: lvl = slow;
      LED_FAST: lvl = fast;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/e1_led_blinker_n_if.sv
// Shift-register LED handshake: sr_val word, sr_go pulse, sr_rdy idle.
// master = blinker (drives val/go), slave = shift interface (drives rdy).
interface e1_led_blinker_n_if #(
  parameter int LED_N = 4
);
  logic [LED_N-1:0] sr_val;
  logic             sr_go;
  logic             sr_rdy;

  modport master (
    output sr_val,
    output sr_go,
    input  sr_rdy
  );

  modport slave (
    input  sr_val,
    input  sr_go,
    output sr_rdy
  );
endinterface

// File: rtl/e1_led_blinker_n_flash.sv
// Single-LED activity flash timer: a strobe while idle loads FLASH_TICKS,
// ticks count it down. Ports: clk, rst_n, act_stb_i, tick_i, active_o.
module e1_led_blinker_n_flash
  import e1_led_blinker_n_pkg::*;
#(
  parameter int FLASH_TICKS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic act_stb_i,
  input  logic tick_i,
  output logic active_o
);

  logic [FLASH_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      (cnt_q == '0) && act_stb_i:
        cnt_d = FLASH_W'(FLASH_TICKS);
      (cnt_q != '0) && tick_i:
        cnt_d = cnt_q - FLASH_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A strobe shows in the pattern the same cycle it loads the counter.
  assign active_o = (cnt_q != '0) | act_stb_i;

endmodule

// File: rtl/e1_led_blinker_n.sv
// LED pattern engine: led_state modes + act_stb flashes -> serial LED word.
// Ports: clk, rst_n, led_state[2*LED_N], act_stb[LED_N], sr (master).
module e1_led_blinker_n
  import e1_led_blinker_n_pkg::*;
#(
  parameter  int N_PORT        = 2,
  parameter  int TICK_LOG2     = 21,
  parameter  int FLASH_TICKS   = 1,
  parameter  int REFRESH_TICKS = 16,
  localparam int LED_N         = 2 * N_PORT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*LED_N-1:0] led_state,
  input  logic [LED_N-1:0]   act_stb,
  e1_led_blinker_n_if.master sr
);

  localparam logic [REFRESH_W-1:0] REF_MAX =
    REFRESH_W'(REFRESH_TICKS);

  logic [TICK_LOG2-1:0] tcnt_q;
  logic                 tick_q;
  logic [PHASE_W-1:0]   phase_q;
  logic [LED_N-1:0]     flash_act;
  logic [LED_N-1:0]     pat_d, pat_q;
  logic [LED_N-1:0]     val_q;
  logic [REFRESH_W-1:0] ref_q;
  logic                 force_q;
  logic                 go_q;
  logic                 dirty;
  xfer_st_e             st_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q  <= '0;
      tick_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      tcnt_q  <= tcnt_q + TICK_LOG2'(1);
      tick_q  <= &tcnt_q;
      phase_q <= phase_q + PHASE_W'(tick_q);
    end
  end

  for (genvar g = 0; g < LED_N; g++) begin : g_flash
    e1_led_blinker_n_flash #(
      .FLASH_TICKS (FLASH_TICKS)
    ) u_flash (
      .clk       (clk),
      .rst_n     (rst_n),
      .act_stb_i (act_stb[g]),
      .tick_i    (tick_q),
      .active_o  (flash_act[g])
    );
  end

  always_comb begin
    pat_d = '0;
    for (int i = 0; i < LED_N; i++) begin
      pat_d[i] = led_base(led_state[2*i +: 2],
                          phase_q[2], phase_q[0])
               ^ flash_act[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pat_q <= '0;
    else        pat_q <= pat_d;
  end

  assign dirty = force_q
               | (pat_q != val_q)
               | (ref_q == REF_MAX);

  // Refresh counter saturates so a long sr_rdy stall still
  // leaves exactly one pending resend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      go_q    <= 1'b0;
      val_q   <= '0;
      ref_q   <= '0;
      force_q <= 1'b1;
    end else begin
      go_q <= 1'b0;
      if (tick_q && (ref_q != REF_MAX))
        ref_q <= ref_q + REFRESH_W'(1);
      unique case (st_q)
        ST_IDLE: begin
          if (dirty && sr.sr_rdy) begin
            go_q    <= 1'b1;
            val_q   <= pat_q;
            ref_q   <= '0;
            force_q <= 1'b0;
            st_q    <= ST_GUARD;
          end
        end
        ST_GUARD: st_q <= ST_WAIT;
        ST_WAIT: begin
          if (sr.sr_rdy) st_q <= ST_IDLE;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign sr.sr_val = val_q;
  assign sr.sr_go  = go_q;

endmodule

// File: tb/tb_e1_led_blinker_n.sv
// Self-checking bench for e1_led_blinker_n (N_PORT=4, 16-cycle tick).
// Arithmetic reference model for the LED pattern, plus directed sequences.
module tb_e1_led_blinker_n;

  localparam int NP = 4;
  localparam int TL = 4;
  localparam int FT = 2;
  localparam int RT = 16;
  localparam int LN = 2 * NP;
  localparam int P  = 1 << TL;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2*LN-1:0] led_state = '0;
  logic [LN-1:0]   act_stb = '0;

  e1_led_blinker_n_if #(.LED_N(LN)) sr_if ();

  e1_led_blinker_n #(
    .N_PORT        (NP),
    .TICK_LOG2     (TL),
    .FLASH_TICKS   (FT),
    .REFRESH_TICKS (RT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .led_state (led_state),
    .act_stb   (act_stb),
    .sr        (sr_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int ntest = 0;
  int nfail = 0;

  // model state
  int            k;
  int            end_e [LN];
  logic [LN-1:0] pat_cur, pat_old, exp_val;
  int            since_go;
  int            ngo = 0;

  typedef struct {
    logic [2*LN-1:0] ls;
    logic [LN-1:0]   exp;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      if (nfail < 40)
        $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pattern the design should register at edge k: mode level from the
  // tick phase in force before the edge, XOR a flash window per LED.
  task automatic model_edge();
    int ph;
    logic [1:0] m;
    logic base, busy;
    ph = (k >= 2) ? ((k - 2) / P) % 8 : 0;
    pat_old = pat_cur;
    for (int i = 0; i < LN; i++) begin
      m = led_state[2*i +: 2];
      case (m)
        2'd0: base = 1'b0;
        2'd1: base = 1'b1;
        2'd2: base = (ph >= 4);
        default: base = (ph % 2 == 1);
      endcase
      busy = (k - 1) < end_e[i];
      if (act_stb[i] && !busy)
        end_e[i] = ((k - 1) / P + FT) * P + 1;
      pat_cur[i] = base ^ (busy | act_stb[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    model_edge();
    #1;
    if (sr_if.sr_go === 1'b1) begin
      chk("go_val", sr_if.sr_val, pat_old);
      chk("go_spacing", since_go + 1 >= 3, 1);
      exp_val  = pat_old;
      since_go = 0;
      ngo++;
    end else begin
      chk("val_stable", sr_if.sr_val, exp_val);
      since_go++;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_go", sr_if.sr_go, 0);
    chk("rst_val", sr_if.sr_val, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    k        = 0;
    pat_cur  = '0;
    pat_old  = '0;
    exp_val  = '0;
    since_go = 100;
    foreach (end_e[i]) end_e[i] = 0;
  endtask

  int g0, nchg, last0, last1, bad0, bad1, n0, n1;
  int k1, exp_low, lowcnt, rises, guard, n33;
  logic [LN-1:0] prev;
  logic prevb;

  initial begin
    tbl[0] = '{16'h0000, 8'h00};
    tbl[1] = '{16'h0001, 8'h01};
    tbl[2] = '{16'h5555, 8'hFF};
    tbl[3] = '{16'h4004, 8'h82};
    tbl[4] = '{16'h1111, 8'h55};
    tbl[5] = '{16'h0040, 8'h08};
    tbl[6] = '{16'h5500, 8'hF0};

    sr_if.sr_rdy = 1'b1;
    #12;
    apply_reset();

    // reset release: one go, then silence until refresh
    g0 = ngo;
    repeat (3) step();
    chk("t1_first_go", ngo - g0, 1);
    chk("t1_val0", sr_if.sr_val, 0);
    g0 = ngo;
    repeat (RT * P - 12) step();
    chk("t1_quiet", ngo - g0, 0);
    g0 = ngo;
    repeat (20) step();
    chk("t1_refresh", ngo - g0, 1);

    // LED 3 on: go two cycles after sampling
    repeat (4) step();
    led_state = 16'h0040;
    step();
    chk("t2_no_go_yet", sr_if.sr_go, 0);
    step();
    chk("t2_go", sr_if.sr_go, 1);
    chk("t2_val", sr_if.sr_val, 8'h08);
    repeat (20) step();
    chk("t2_hold", sr_if.sr_val, 8'h08);

    // static mode table
    for (int i = 0; i < 7; i++) begin
      led_state = tbl[i].ls;
      repeat (8) step();
      chk($sformatf("tbl%0d", i), sr_if.sr_val, tbl[i].exp);
    end

    // blink periods
    led_state = 16'h004B;
    repeat (20) step();
    g0 = ngo; nchg = 0; bad0 = 0; bad1 = 0;
    n0 = 0; n1 = 0; last0 = -1; last1 = -1;
    prev = sr_if.sr_val;
    repeat (300) begin
      step();
      if (sr_if.sr_val != prev) nchg++;
      if (sr_if.sr_val[0] != prev[0]) begin
        if (last0 >= 0 && k - last0 != P) bad0++;
        last0 = k; n0++;
      end
      if (sr_if.sr_val[1] != prev[1]) begin
        if (last1 >= 0 && k - last1 != 4 * P) bad1++;
        last1 = k; n1++;
      end
      prev = sr_if.sr_val;
    end
    chk("blink_fast_period", bad0, 0);
    chk("blink_slow_period", bad1, 0);
    chk("blink_fast_count", n0 >= 18, 1);
    chk("blink_slow_count", n1 >= 4, 1);
    chk("blink_go_vs_chg", ngo - g0, nchg);

    // flash with an ignored second strobe across a tick
    led_state = 16'h0010;
    repeat (8) step();
    guard = 0;
    while (((k + 1) % P) != 0 && guard < 40) begin
      step();
      guard++;
    end
    k1 = k + 1;
    exp_low = ((k1 - 1) / P + FT) * P + 2 - k1;
    lowcnt = 0; rises = 0;
    prevb = sr_if.sr_val[2];
    for (int i = 0; i < 60; i++) begin
      act_stb = (i == 0 || i == 3) ? 8'h04 : 8'h00;
      step();
      if (!sr_if.sr_val[2]) lowcnt++;
      if (sr_if.sr_val[2] && !prevb) rises++;
      prevb = sr_if.sr_val[2];
    end
    act_stb = '0;
    chk("flash_low_cycles", lowcnt, exp_low);
    chk("flash_one_pulse", rises, 1);
    chk("flash_back_high", sr_if.sr_val[2], 1);

    // sr_rdy stall over three changes
    sr_if.sr_rdy = 1'b0;
    repeat (3) step();
    g0 = ngo;
    led_state = 16'h0001; repeat (3) step();
    led_state = 16'h0100; repeat (3) step();
    led_state = 16'h5050; repeat (3) step();
    chk("hold_no_go", ngo - g0, 0);
    sr_if.sr_rdy = 1'b1;
    g0 = ngo;
    step();
    chk("hold_go_now", sr_if.sr_go, 1);
    chk("hold_latest", sr_if.sr_val, 8'hCC);
    repeat (12) step();
    chk("hold_one_go", ngo - g0, 1);

    // random traffic against the model
    g0 = ngo;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0)
        led_state = 16'($urandom);
      act_stb = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      sr_if.sr_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("rand_gos", (ngo - g0) > 10, 1);

    // reset in WAIT, then full resend
    act_stb = '0;
    sr_if.sr_rdy = 1'b1;
    led_state = 16'h0000;
    repeat (40) step();
    led_state = 16'h0505;
    guard = 0;
    do begin
      step();
      guard++;
    end while (sr_if.sr_go !== 1'b1 && guard < 10);
    chk("rst_pre_go", sr_if.sr_go, 1);
    sr_if.sr_rdy = 1'b0;
    step();
    step();
    apply_reset();
    sr_if.sr_rdy = 1'b1;
    n33 = 0;
    repeat (12) begin
      step();
      if (sr_if.sr_go === 1'b1 && sr_if.sr_val === 8'h33) n33++;
    end
    chk("rst_resend_once", n33, 1);
    chk("rst_final_val", sr_if.sr_val, 8'h33);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
